canny_frame_writer: RTL

Output-side consumer for the Canny edge pipeline. Pops 8-bit edge pixels from the pipeline's output FIFO (`img_out_*` side), packs four pixels per 32-bit word, and writes one full frame (WIDTH×HEIGHT pixels) to the DDR3 frame buffer over an Avalon-MM write-only master. It is the reader for the pipeline's output stream. A host `start` pulse and base address launch each frame; `done` reports completion.

---
 rtl/canny_frame_writer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/canny_frame_writer.sv
// Output-side frame writer for the Canny edge pipeline: pops 8-bit edge pixels from a
// first-word-fall-through FIFO, packs four pixels per word and writes them over Avalon-MM.
module canny_frame_writer #(
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 720,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frame_count,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [7:0]            in_dout,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_write,
  output logic [31:0]           avm_writedata,
  output logic [3:0]            avm_byteenable,
  input  logic                  avm_waitrequest
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_GATHER, S_WRITE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic [3:0]              be_q, be_d;
  logic [1:0]              lane_q, lane_d;
  logic [PW-1:0]           pix_q, pix_d;
  logic                    last_q, last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    write_q, write_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;

  logic pop;
  logic accept;
  logic last_pix;

  assign pop      = (state_q == S_GATHER) && !in_empty;
  assign accept   = (state_q == S_WRITE) && !avm_waitrequest;
  assign last_pix = (pix_q == LAST_PIX);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_GATHER;
      S_GATHER: if (pop && (lane_q == 2'd3 || last_pix)) state_d = S_WRITE;
      S_WRITE:  if (accept) state_d = last_q ? S_IDLE : S_GATHER;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    in_rd_en    = pop;
    addr_d      = addr_q;
    data_d      = data_q;
    be_d        = be_q;
    lane_d      = lane_q;
    pix_d       = pix_q;
    last_d      = last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = base_addr;
          data_d = '0;
          be_d   = '0;
          lane_d = '0;
          pix_d  = '0;
          last_d = 1'b0;
        end
      end
      S_GATHER: begin
        if (pop) begin
          data_d[{lane_q, 3'b000} +: 8] = in_dout;
          be_d[lane_q] = 1'b1;
          lane_d       = lane_q + 2'd1;
          pix_d        = pix_q + PW'(1);
          last_d       = last_pix;
        end
      end
      S_WRITE: begin
        if (accept) begin
          addr_d = addr_q + ADDR_WIDTH'(4);
          data_d = '0;
          be_d   = '0;
          lane_d = '0;
        end
      end
      default: ;
    endcase
    busy_d      = (state_d != S_IDLE);
    write_d     = (state_d == S_WRITE);
    done_d      = accept && last_q;
    frame_cnt_d = frame_cnt_q + {15'b0, done_d};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      data_q      <= '0;
      be_q        <= '0;
      lane_q      <= '0;
      pix_q       <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      write_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      addr_q      <= addr_d;
      data_q      <= data_d;
      be_q        <= be_d;
      lane_q      <= lane_d;
      pix_q       <= pix_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      write_q     <= write_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign frame_count    = frame_cnt_q;
  assign avm_address    = addr_q;
  assign avm_write      = write_q;
  assign avm_writedata  = data_q;
  assign avm_byteenable = be_q;

endmodule
